// File: rtl/coin_if.sv
// Coin acceptor bus: raw buttons and FSM controls in, credit and accept/reject pulses out.
interface coin_if;
    logic       C;
    logic       Q;
    logic       enable;
    logic       clear;
    logic [7:0] credit;
    logic       coin_accepted;
    logic       coin_rejected;
    logic       full;

    modport master (
        output C, Q, enable, clear,
        input  credit, coin_accepted, coin_rejected, full
    );

    modport slave (
        input  C, Q, enable, clear,
        output credit, coin_accepted, coin_rejected, full
    );
endinterface

// File: rtl/coin_intake.sv
// Coin acceptor front end: per-button sync/debounce/edge detect, one-coin-per-cycle
// arbitration, and a saturating-by-refusal credit accumulator.

module coin_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    logic [1:0] sync;
    logic [7:0] cnt;
    logic       db;
    logic       db_d;

    // db/db_d reset high so a button held through reset never looks like a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b00;
            cnt  <= 8'd0;
            db   <= 1'b1;
            db_d <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            db_d <= db;
            if (sync[1] == db) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(DB_CYCLES - 1)) begin
                db  <= sync[1];
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign evt = db & ~db_d;
endmodule

module coin_intake #(
    parameter int DB_CYCLES  = 4,
    parameter int MAX_CREDIT = 11
) (
    input  logic   clk,
    input  logic   rst,
    coin_if.slave  bus
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] evt;
    logic                 pend_q;
    logic                 coin_vld;
    logic [3:0]           val;
    logic [8:0]           sum;
    logic [7:0]           credit;
    logic                 accepted;
    logic                 rejected;

    // lane 0 = 100-coin, lane 1 = 500-coin
    assign raw = {bus.Q, bus.C};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk (clk),
                .rst (rst),
                .raw (raw[i]),
                .evt (evt[i])
            );
        end
    endgenerate

    // A deferred Q wins over anything new; otherwise C beats Q
    assign coin_vld = pend_q | evt[0] | evt[1];
    assign val      = (pend_q | ~evt[0]) ? 4'd5 : 4'd1;
    assign sum      = {1'b0, credit} + {5'd0, val};

    always_ff @(posedge clk) begin
        if (rst) begin
            credit   <= 8'd0;
            accepted <= 1'b0;
            rejected <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            accepted <= 1'b0;
            rejected <= 1'b0;
            pend_q   <= ~pend_q & evt[0] & evt[1];
            if (bus.clear) begin
                credit   <= 8'd0;
                rejected <= coin_vld;
            end else if (coin_vld) begin
                if (!bus.enable || sum > 9'(MAX_CREDIT)) begin
                    rejected <= 1'b1;
                end else begin
                    credit   <= sum[7:0];
                    accepted <= 1'b1;
                end
            end
        end
    end

    assign bus.credit        = credit;
    assign bus.coin_accepted = accepted;
    assign bus.coin_rejected = rejected;
    assign bus.full          = (credit >= 8'(MAX_CREDIT));
endmodule

// File: tb/tb_coin_intake.sv
// Self-checking bench for coin_intake: table of clean presses plus hand-built
// glitch, simultaneous, reset-with-pending and held-through-reset sequences.
module tb_coin_intake;
    localparam int DB   = 4;
    localparam int MAXC = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coin_if bus();

    coin_intake #(.DB_CYCLES(DB), .MAX_CREDIT(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit acc;
        int credit;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit q;
        bit en;
        bit clr_proc;
        bit pre_clear;
        bit exp_acc;
        int exp_credit;
    } vec_t;
    vec_t tbl[13];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.coin_accepted || bus.coin_rejected) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_acc", {31'd0, bus.coin_accepted}, {31'd0, e.acc});
                chk("pulse_rej", {31'd0, bus.coin_rejected}, {31'd0, !e.acc});
                chk("pulse_credit", {24'd0, bus.credit}, e.credit);
                chk("pulse_full", {31'd0, bus.full}, {31'd0, e.credit >= MAXC});
            end
        end
    end

    task automatic press(input bit c, input bit q, input bit clr_proc,
                         input bit exp_acc, input int exp_credit);
        int c0;
        @(negedge clk);
        c0 = cyc;
        bus.C = c;
        bus.Q = q;
        sbq.push_back('{c0 + DB + 3, exp_acc, exp_credit});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.clear = clr_proc && (i == DB + 2);
        end
        bus.C = 1'b0;
        bus.Q = 1'b0;
        bus.clear = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_no_coin", {24'd0, bus.credit}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        tbl[0]  = '{0, 1, 0, 0, 1, 1};
        tbl[1]  = '{1, 1, 0, 1, 1, 5};
        tbl[2]  = '{1, 1, 0, 0, 1, 10};
        tbl[3]  = '{1, 1, 0, 0, 0, 10};
        tbl[4]  = '{0, 1, 0, 0, 1, 11};
        tbl[5]  = '{0, 1, 0, 0, 0, 11};
        tbl[6]  = '{1, 1, 0, 1, 1, 5};
        tbl[7]  = '{0, 1, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 1, 5};
        tbl[10] = '{1, 0, 0, 0, 0, 5};
        tbl[11] = '{1, 1, 0, 0, 1, 10};
        tbl[12] = '{0, 1, 0, 0, 1, 11};

        bus.C = 1'b0;
        bus.Q = 1'b0;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_credit", {24'd0, bus.credit}, 32'd0);
        chk("rst_acc", {31'd0, bus.coin_accepted}, 32'd0);
        chk("rst_rej", {31'd0, bus.coin_rejected}, 32'd0);
        chk("rst_full", {31'd0, bus.full}, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int n = 0; n < 13; n++) begin
            if (tbl[n].pre_clear) pulse_clear();
            bus.enable = tbl[n].en;
            press(1'b0 ^ tbl[n].q ? 1'b0 : 1'b1, tbl[n].q, tbl[n].clr_proc,
                  tbl[n].exp_acc, tbl[n].exp_credit);
            chk("tbl_drain", sbq.size(), 32'd0);
            chk("tbl_credit", {24'd0, bus.credit}, tbl[n].exp_credit);
            chk("tbl_full", {31'd0, bus.full}, {31'd0, tbl[n].exp_credit >= MAXC});
            if (n == 0) begin
                // glitch shorter than the debounce window must vanish
                @(negedge clk);
                bus.C = 1'b1;
                repeat (3) @(negedge clk);
                bus.C = 1'b0;
                repeat (12) @(negedge clk);
                chk("glitch_credit", {24'd0, bus.credit}, 32'd1);
            end
        end
        bus.enable = 1'b1;

        // Simultaneous C and Q: C first, deferred Q one edge later
        pulse_clear();
        @(negedge clk);
        c0 = cyc;
        bus.C = 1'b1;
        bus.Q = 1'b1;
        sbq.push_back('{c0 + DB + 3, 1'b1, 1});
        sbq.push_back('{c0 + DB + 4, 1'b1, 6});
        repeat (10) @(negedge clk);
        bus.C = 1'b0;
        bus.Q = 1'b0;
        repeat (12) @(negedge clk);
        chk("simul_drain", sbq.size(), 32'd0);
        chk("simul_credit", {24'd0, bus.credit}, 32'd6);

        // Reset lands on the edge the deferred Q would be processed
        @(negedge clk);
        c0 = cyc;
        bus.C = 1'b1;
        bus.Q = 1'b1;
        sbq.push_back('{c0 + DB + 3, 1'b1, 7});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            rst = (i == DB + 3);
        end
        bus.C = 1'b0;
        bus.Q = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstpend_drain", sbq.size(), 32'd0);
        chk("rstpend_credit", {24'd0, bus.credit}, 32'd0);

        // Button held through reset release must not register
        @(negedge clk);
        bus.C = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_credit", {24'd0, bus.credit}, 32'd0);
        bus.C = 1'b0;
        repeat (12) @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1);
        chk("held_drain", sbq.size(), 32'd0);
        chk("held_after_credit", {24'd0, bus.credit}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
